mem_port_arbiter: RTL and testbench

Shares one single-ported, word-wide memory between the instruction-fetch port and the load/store port of `riscv_pipelined_datapath`, replacing the separate combinational instruction and data arrays. Each request is sequenced through a three-state FSM with one outstanding memory transaction. The block produces per-port completion pulses and a pipeline stall. A watchdog aborts transactions when the memory never acknowledges.

---
 rtl/riscv_mem_pkg.sv | 19 +
 rtl/mem_arb_watchdog.sv | 32 +++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// FSM states, port owner encoding and default datapath width.
package riscv_mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IPORT,
    OWN_DPORT
  } owner_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Memory acknowledge watchdog for mem_port_arbiter.
// Counts busy cycles from 1 and flags the cycle that reaches TIMEOUT.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;

  // Reload to 1 so the first busy cycle is already count 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= ONE;
    end else if (clear) begin
      cnt_q <= ONE;
    end else if (enable && cnt_q != LIMIT) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory shared by fetch and load/store, one txn in flight.
// Define MEM_ARB_RR_EN for round-robin on conflicts (else data wins).
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW      = XLEN,
  parameter int DW      = XLEN,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic          stall,
  output logic          err
);

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t gnt;

  logic arb;
  logic busy;
  logic resp;
  logic expired;
  logic prefer_i;
  logic take_d;
  logic take_i;

  assign busy = (state_q == S_BUSY);
  assign resp = (state_q == S_RESP);
  assign arb  = (state_q == S_IDLE) || resp;

`ifdef MEM_ARB_RR_EN
  owner_t last_q;

  // Only contested grants move the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_IPORT;
    end else if (arb && i_req && d_req) begin
      last_q <= gnt;
    end
  end

  assign prefer_i = (last_q == OWN_DPORT);
`else
  assign prefer_i = 1'b0;
`endif

  assign take_d = arb & d_req & ~(i_req & prefer_i);
  assign take_i = arb & i_req & ~take_d;

  always_comb begin
    gnt = OWN_NONE;
    unique case (1'b1)
      take_d:  gnt = OWN_DPORT;
      take_i:  gnt = OWN_IPORT;
      default: gnt = OWN_NONE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (gnt != OWN_NONE) begin
          state_d = S_BUSY;
          owner_d = gnt;
        end else begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      end
      S_BUSY: begin
        if (m_ack || expired) begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (gnt == OWN_DPORT) begin
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (gnt == OWN_IPORT) begin
        m_we    <= 1'b0;
        m_addr  <= i_addr;
      end
      if (busy && m_ack) begin
        if (owner_q == OWN_IPORT) begin
          i_rdata <= m_rdata;
        end
        if (owner_q == OWN_DPORT && !m_we) begin
          d_rdata <= m_rdata;
        end
      end
      // An ack in the expiry cycle still counts as a normal completion.
      if (busy && expired && !m_ack) begin
        err <= 1'b1;
      end
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!busy),
    .enable (busy),
    .expired(expired)
  );

  assign m_req  = busy;
  assign i_done = resp && (owner_q == OWN_IPORT);
  assign d_done = resp && (owner_q == OWN_DPORT);
  assign stall  = (i_req & ~i_done) | (d_req & ~d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-programmable memory.
// Requesters drop or advance their request in the done cycle.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        stall;
  logic        err;

  mem_port_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .stall(stall), .err(err)
  );

  typedef struct {
    bit          port;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          busy;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  exp_t        sbq[$];
  logic [31:0] i_list[$];
  dreq_t       d_list[$];

  int          n_chk;
  int          n_err;
  int          cyc;
  int          t_last;
  int          mem_lat;
  int          mcnt;
  int          busy_cnt;
  logic        force_ack;
  logic        prev_mreq;
  logic [31:0] exp_i;
  logic [31:0] exp_d;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (m_req) mcnt++;
    else mcnt = 0;
    m_ack = force_ack | (m_req && mem_lat != 0 && mcnt == mem_lat);
    m_rdata = force_ack ? 32'hBAD0_BAD0 : mem_word(m_addr);
  end

  always @(posedge clk) begin
    #1;
    if (i_done && i_list.size() != 0) void'(i_list.pop_front());
    if (d_done && d_list.size() != 0) void'(d_list.pop_front());
    i_req = (i_list.size() != 0);
    if (i_req) i_addr = i_list[0];
    d_req = (d_list.size() != 0);
    if (d_req) begin
      d_we    = d_list[0].we;
      d_addr  = d_list[0].addr;
      d_wdata = d_list[0].wdata;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_mreq = 1'b0;
    end else begin
      if (m_req) begin
        if (!prev_mreq) busy_cnt = 0;
        busy_cnt++;
        if (sbq.size() == 0) begin
          chk("req_unexp", 1, 0);
        end else begin
          chk("m_addr", m_addr, sbq[0].addr);
          chk("m_we", m_we, sbq[0].we);
          if (sbq[0].we) chk("m_wdata", m_wdata, sbq[0].wdata);
          chk("stall_busy", stall, 1);
        end
      end
      if (i_done || d_done) begin
        if (sbq.size() == 0) begin
          chk("done_unexp", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("done_port", d_done, e.port);
          chk("done_both", i_done & d_done, 0);
          if (e.port) chk("d_rdata", d_rdata, e.rdata);
          else chk("i_rdata", i_rdata, e.rdata);
          if (e.lat >= 0) chk("latency", cyc - t_last, e.lat);
          if (e.busy >= 0) chk("busy_cycles", busy_cnt, e.busy);
        end
        t_last = cyc;
      end
      prev_mreq = m_req;
    end
  end

  task automatic push_i(input logic [31:0] a, input int lat,
                        input int busy);
    exp_t e;
    if (mem_lat != 0) exp_i = mem_word(a);
    e.port = 0; e.addr = a; e.we = 0; e.wdata = 0;
    e.rdata = exp_i; e.lat = lat; e.busy = busy;
    sbq.push_back(e);
    i_list.push_back(a);
  endtask

  task automatic push_d(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input int lat,
                        input int busy);
    exp_t  e;
    dreq_t r;
    if (!we && mem_lat != 0) exp_d = mem_word(a);
    e.port = 1; e.addr = a; e.we = we; e.wdata = wd;
    e.rdata = exp_d; e.lat = lat; e.busy = busy;
    sbq.push_back(e);
    r.we = we; r.addr = a; r.wdata = wd;
    d_list.push_back(r);
  endtask

  task automatic start();
    t_last = cyc + 1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((sbq.size() != 0 || i_list.size() != 0 ||
            d_list.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) begin
      chk("idle_wait", 0, 1);
      sbq.delete(); i_list.delete(); d_list.delete();
    end
    @(negedge clk);
    chk("stall_idle", stall, 0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; t_last = 0;
    mem_lat = 1; mcnt = 0; busy_cnt = 0;
    force_ack = 0; prev_mreq = 0;
    exp_i = 0; exp_d = 0;
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    m_ack = 0; m_rdata = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_err", err, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    rst = 0;
    @(negedge clk);

    mem_lat = 2; start();
    push_i(32'h10, 3, 2);
    wait_idle(40);
    chk("fetch_rdata", i_rdata, 32'h0050_0093);

    mem_lat = 1; start();
    push_d(1'b0, 32'h40, 32'h0, 2, 1);
    push_i(32'h14, 2, 1);
    wait_idle(40);

    start();
`ifdef MEM_ARB_RR_EN
    push_i(32'h18, 2, 1);
    push_d(1'b0, 32'h44, 32'h0, 2, 1);
`else
    push_d(1'b0, 32'h44, 32'h0, 2, 1);
    push_i(32'h18, 2, 1);
`endif
    wait_idle(40);

    mem_lat = 3; start();
    push_d(1'b1, 32'h80, 32'hDEAD_BEEF, 4, 3);
    wait_idle(40);
    chk("store_keep", d_rdata, mem_word(32'h44));

    mem_lat = TO; start();
    push_d(1'b0, 32'h100, 32'h0, TO + 1, TO);
    wait_idle(40);
    chk("err_edge_ack", err, 0);

    mem_lat = 0; start();
    push_i(32'h20, TO + 1, TO);
    wait_idle(40);
    chk("err_set", err, 1);

    mem_lat = 1; start();
    push_d(1'b0, 32'h24, 32'h0, 2, 1);
    wait_idle(40);
    chk("err_sticky", err, 1);

    start();
    for (int k = 0; k < 4; k++) push_i(32'h30 + 32'(4 * k), 2, 1);
    wait_idle(60);

    mem_lat = 0;
    push_i(32'h50, -1, -1);
    for (int k = 0; k < 10 && !m_req; k++) @(negedge clk);
    chk("rst_test_busy", m_req, 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_m_req", m_req, 0);
    chk("arst_i_done", i_done, 0);
    chk("arst_m_we", m_we, 0);
    chk("arst_err", err, 0);
    chk("arst_m_addr", m_addr, 0);
    chk("arst_i_rdata", i_rdata, 0);
    chk("arst_d_rdata", d_rdata, 0);
    sbq.delete(); i_list.delete(); d_list.delete();
    exp_i = 0; exp_d = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    force_ack = 1;
    @(negedge clk);
    force_ack = 0;
    repeat (4) @(negedge clk);
    chk("late_ack_i", i_rdata, 0);
    chk("late_ack_d", d_rdata, 0);
    chk("late_ack_req", m_req, 0);
    chk("late_ack_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d exp 0", cyc);
    $fatal(1, "bench did not finish");
  end

endmodule
